rr_req_arbiter: RTL and testbench
=================================

// Module: rr_req_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource among N requesters, using priority-encode selection.
//  Sits in front of the shared resource and produces:
//   - a registered one-hot grant;
//   - the encoded grant index and a grant-valid flag.
//  The grant is held while the owner keeps its request, or until a hold limit expires.
//  The start point rotates so that every requester is eventually served.
// PARAMETERS
//  N         8   number of requesters (2..8)
//  IDX_W     3   width of the encoded grant index (clog2(N))
//  MAX_HOLD  16  maximum cycles one grant may last (>=2)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  en        in   1      arbitration enable; 0 = no new grants are issued
//  req       in   N      request vector; bit i = requester i
//  gnt       out  N      one-hot grant (registered); all zero when idle
//  gnt_idx   out  IDX_W  index of the granted requester; 0 when idle
//  gnt_vld   out  1      1 while a grant is active
//  timeout   out  1      single-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
//   - state=IDLE, ptr=0, hold_cnt=0.
//  States: IDLE, BUSY.
//  IDLE:
//   - if en=1 and req!=0, select the first set bit of req, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   - gnt/gnt_idx/gnt_vld update at the next edge (latency 1 cycle); hold_cnt=0; go to BUSY.
//   - if en=0 or req=0, stay in IDLE with outputs 0.
//  BUSY (owner = gnt_idx):
//   - release: req[owner]=0 -> next edge: gnt=0, gnt_vld=0, gnt_idx=0, ptr=(owner+1) mod N, go to IDLE.
//   - timeout: req[owner]=1 and hold_cnt==MAX_HOLD-1 -> same as release, and timeout=1 for that one cycle.
//   - otherwise: hold_cnt+1; grant is unchanged.
//   - requests from other requesters are ignored in BUSY.
//  Idle cycle: there is always exactly one idle cycle (gnt_vld=0) between consecutive grants.
//  en in BUSY: en=0 does not revoke the current grant; it only blocks new grants from IDLE.
//  Grant lifetime: a grant lasts between 1 and MAX_HOLD cycles inclusive.
//  Fairness: with all N requesting continuously, the grant order is 0,1,...,N-1,0,...
//   - no requester waits for more than N-1 other grants.
//  Wrap-around: ptr and the scan wrap modulo N; ptr=N-1 with owner N-1 -> ptr=0.
//  Unused bits: req bits >= N are treated as 0.
//  Invariants: gnt is always zero or one-hot; gnt[gnt_idx]=1 whenever gnt_vld=1.
//  Reset mid-grant: all outputs clear immediately, asynchronously; ptr returns to 0.
// TESTING
//  1 Reset: rst_n=0 mid-grant (owner 5) -> gnt=0, gnt_vld=0 at once;
//    after release, req=8'h20 -> gnt=8'h20, gnt_idx=5 one cycle later.
//  2 Rotation: req=8'hFF held continuously, MAX_HOLD=16 -> owners 0,1,...,7,0;
//    each owner for 16 cycles; timeout pulses every 17 cycles.
//  3 Release: req=8'h09; owner 0 drops its request after 3 cycles ->
//    1 idle cycle, then gnt=8'h08, gnt_idx=3; after that release, ptr=4.
//  4 Wrap: ptr=7, req=8'h82 -> owner 7; after release -> owner 1, ptr=0 is skipped
//    because req[0]=0.
//  5 Enable: en=0 with req=8'h10 -> no grant; en=1 -> gnt=8'h10 next edge;
//    en=0 during BUSY -> grant is kept until release.
//  6 Single requester: req=8'h04 held for 40 cycles -> grants of 16, 16 and 6 cycles,
//    each followed by 1 idle cycle; timeout pulses twice.

Source files
------------

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with registered one-hot grant, hold limit and timeout pulse.
// The scan start pointer advances past each released owner.
module rr_req_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [HW-1:0]    hold_cnt;

    logic [IDX_W-1:0] hi_sel;
    logic [IDX_W-1:0] lo_sel;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] ptr_nxt;
    logic             hi_found;
    logic             lo_found;
    logic             any_req;
    logic             owner_req;
    logic             hold_end;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest below it.
    always_comb begin
        hi_sel   = '0;
        lo_sel   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_sel   = IDX_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_sel   = IDX_W'(i);
                end
            end
        end
    end

    assign sel       = hi_found ? hi_sel : lo_sel;
    assign any_req   = hi_found | lo_found;
    assign owner_req = req[gnt_idx];
    assign hold_end  = (hold_cnt == HW'(MAX_HOLD - 1));
    assign ptr_nxt   = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && any_req) begin
                        state    <= BUSY;
                        gnt      <= N'(1) << sel;
                        gnt_idx  <= sel;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!owner_req || hold_end) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        gnt_idx  <= '0;
                        gnt_vld  <= 1'b0;
                        ptr      <= ptr_nxt;
                        hold_cnt <= '0;
                        timeout  <= owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter with a behavioural reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_rr_req_arbiter;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             timeout;

    int errors = 0;
    int checks = 0;

    rr_req_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = idle), cycles owned so far, rotating start.
    int m_owner = -1;
    int m_age   = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_age   = 0;
            m_ptr   = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (!req[m_owner] || m_age == MAX_HOLD) begin
                    m_to    = req[m_owner];
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end else begin
                    m_age++;
                end
            end else if (en) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_age   = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_gnt;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        check("model_gnt", 32'(gnt), 32'(e_gnt));
        check("model_idx", 32'(gnt_idx), (m_owner >= 0) ? m_owner : 0);
        check("model_vld", 32'(gnt_vld), 32'(m_owner >= 0));
        check("model_timeout", 32'(timeout), 32'(m_to));
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt_vld) check("gnt_at_idx", 32'(gnt[gnt_idx]), 32'd1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    int runs[$];
    int owners[$];
    int tos;

    // Sample outputs each cycle and record grant run lengths, owners, timeouts.
    task automatic measure(input int total, input int drop_at);
        bit prev;
        int len;
        prev = 1'b0;
        len  = 0;
        tos  = 0;
        runs.delete();
        owners.delete();
        for (int c = 1; c <= total; c++) begin
            if (c == drop_at + 1) req = '0;
            tick(1);
            if (gnt_vld) begin
                if (!prev) begin
                    owners.push_back(int'(gnt_idx));
                    len = 0;
                end
                len++;
            end else if (prev) begin
                runs.push_back(len);
            end
            if (timeout) tos++;
            prev = gnt_vld;
        end
        if (prev) runs.push_back(len);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        tick(2);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_vld", 32'(gnt_vld), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Reset in the middle of a grant to owner 5
        en  = 1'b1;
        req = 8'h20;
        tick(1);
        check("t1_gnt", 32'(gnt), 32'h20);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("t1_async_gnt", 32'(gnt), 32'h0);
        check("t1_async_vld", 32'(gnt_vld), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("t1_regrant_gnt", 32'(gnt), 32'h20);
        check("t1_regrant_idx", 32'(gnt_idx), 32'd5);
        req = '0;
        tick(2);

        // Release by owner 0, then owner 3, then ptr=4 seen via 8'hFF
        do_reset();
        req = 8'h09;
        tick(1);
        check("t3_gnt0", 32'(gnt), 32'h01);
        tick(2);
        req = 8'h08;
        tick(1);
        check("t3_idle", 32'(gnt_vld), 32'h0);
        tick(1);
        check("t3_gnt3", 32'(gnt), 32'h08);
        check("t3_idx3", 32'(gnt_idx), 32'd3);
        req = '0;
        tick(1);
        req = 8'hFF;
        tick(1);
        check("t3_ptr4", 32'(gnt), 32'h10);
        req = '0;
        tick(2);

        // Wrap: owner 6 released makes ptr=7; then 8'h82 -> 7, then 1
        req = 8'h40;
        tick(1);
        check("t4_gnt6", 32'(gnt), 32'h40);
        req = '0;
        tick(1);
        req = 8'h82;
        tick(1);
        check("t4_idx7", 32'(gnt_idx), 32'd7);
        req = 8'h02;
        tick(1);
        check("t4_idle", 32'(gnt_vld), 32'h0);
        tick(1);
        check("t4_gnt1", 32'(gnt), 32'h02);
        check("t4_idx1", 32'(gnt_idx), 32'd1);
        req = '0;
        tick(2);

        // Enable gating
        en  = 1'b0;
        req = 8'h10;
        tick(3);
        check("t5_blocked", 32'(gnt_vld), 32'h0);
        en = 1'b1;
        tick(1);
        check("t5_gnt", 32'(gnt), 32'h10);
        en = 1'b0;
        tick(5);
        check("t5_kept", 32'(gnt), 32'h10);
        req = '0;
        tick(1);
        check("t5_released", 32'(gnt_vld), 32'h0);
        req = 8'h10;
        tick(2);
        check("t5_still_blocked", 32'(gnt_vld), 32'h0);
        req = '0;
        en  = 1'b1;
        tick(1);

        // Single requester held 40 cycles
        req = 8'h04;
        measure(41, 40);
        check("t6_nruns", runs.size(), 3);
        if (runs.size() == 3) begin
            check("t6_run0", runs[0], 16);
            check("t6_run1", runs[1], 16);
            check("t6_run2", runs[2], 6);
        end
        check("t6_timeouts", tos, 2);
        tick(1);

        // Rotation with all requesting
        do_reset();
        req = 8'hFF;
        measure(153, 1000);
        req = '0;
        check("t2_nruns", runs.size(), 9);
        check("t2_timeouts", tos, 9);
        for (int i = 0; i < runs.size(); i++) begin
            check($sformatf("t2_len%0d", i), runs[i], 16);
        end
        for (int i = 0; i < owners.size(); i++) begin
            check($sformatf("t2_owner%0d", i), owners[i], i % N);
        end
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
